// File: rtl/fb_sched_pkg.sv
// Shared types and helpers for the framebuffer write scheduler.
// Address/pixel typedefs, issue-FSM states and the pixel-count helper.
package fb_sched_pkg;

    typedef logic [19:0] fb_addr_t;
    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_WAIT,
        ST_FLIP
    } issue_state_t;

    function automatic int fb_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides; show-ahead read port.
// DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Extra pointer bit tells full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = out_ready && !empty;
    assign out_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Arbitrates CPU pixel writes and the clear/fill engine onto the display write
// port, paces writes against display_busy and defers buffer flips to vblank.
module fb_write_scheduler
    import fb_sched_pkg::*;
#(
    parameter int WIDTH      = 267,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_GUARD = 2,
    parameter int FLIP_PULSE = 2
) (
    input  logic     clk_sys,
    input  logic     reset,
    input  logic     cpu_wr_valid,
    output logic     cpu_wr_ready,
    input  fb_addr_t cpu_wr_addr,
    input  pixel_t   cpu_wr_data,
    input  logic     clear_start,
    input  pixel_t   clear_color,
    output logic     clear_active,
    input  logic     flip_req,
    output logic     flip_pending,
    output logic     flip_done,
    input  logic     vblank,
    output fb_addr_t display_addr,
    output pixel_t   display_data,
    output logic     display_wr,
    input  logic     display_busy,
    output logic     display_flip_framebuffer
);

    localparam fb_addr_t   CLEAR_LAST = fb_addr_t'(fb_pixels(WIDTH, HEIGHT) - 1);
    localparam logic [7:0] GUARD_LAST = 8'(BUSY_GUARD - 1);
    localparam logic [7:0] FLIP_LAST  = 8'(FLIP_PULSE - 1);

    issue_state_t state, state_nx;
    logic [7:0]   cnt, cnt_nx;
    fb_addr_t     clear_addr;
    pixel_t       clear_color_q;
    logic         vblank_q;
    logic         vblank_rise;

    logic         fifo_in_ready;
    logic         fifo_valid;
    logic         fifo_pop;
    fb_addr_t     fifo_addr;
    pixel_t       fifo_data;

    logic         wr_nx;
    fb_addr_t     addr_nx;
    pixel_t       data_nx;
    logic         flip_fb_nx;
    logic         done_nx;
    logic         clear_issue;
    logic         flip_finish;

    // New CPU writes are held off while a flip is pending so they land in the new back buffer.
    assign cpu_wr_ready = fifo_in_ready && !flip_pending;
    assign vblank_rise  = vblank && !vblank_q;

    sync_fifo #(
        .WIDTH($bits(fb_addr_t) + $bits(pixel_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_cpu_fifo (
        .clk      (clk_sys),
        .reset    (reset),
        .in_valid (cpu_wr_valid && !flip_pending),
        .in_ready (fifo_in_ready),
        .in_data  ({cpu_wr_addr, cpu_wr_data}),
        .out_valid(fifo_valid),
        .out_ready(fifo_pop),
        .out_data ({fifo_addr, fifo_data})
    );

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        fifo_pop    = 1'b0;
        wr_nx       = 1'b0;
        addr_nx     = display_addr;
        data_nx     = display_data;
        flip_fb_nx  = 1'b0;
        done_nx     = 1'b0;
        clear_issue = 1'b0;
        flip_finish = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!display_busy) begin
                    if (fifo_valid) begin
                        fifo_pop = 1'b1;
                        wr_nx    = 1'b1;
                        addr_nx  = fifo_addr;
                        data_nx  = fifo_data;
                        cnt_nx   = '0;
                        state_nx = ST_GUARD;
                    end else if (clear_active) begin
                        clear_issue = 1'b1;
                        wr_nx       = 1'b1;
                        addr_nx     = clear_addr;
                        data_nx     = clear_color_q;
                        cnt_nx      = '0;
                        state_nx    = ST_GUARD;
                    end else if (flip_pending && vblank_rise) begin
                        flip_fb_nx = 1'b1;
                        cnt_nx     = '0;
                        state_nx   = ST_FLIP;
                    end
                end
            end
            ST_GUARD: begin
                if (cnt == GUARD_LAST) state_nx = ST_WAIT;
                else                   cnt_nx   = cnt + 8'd1;
            end
            ST_WAIT: begin
                if (!display_busy) state_nx = ST_IDLE;
            end
            ST_FLIP: begin
                if (cnt == FLIP_LAST) begin
                    done_nx     = 1'b1;
                    flip_finish = 1'b1;
                    state_nx    = ST_IDLE;
                end else begin
                    flip_fb_nx = 1'b1;
                    cnt_nx     = cnt + 8'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state                    <= ST_IDLE;
            cnt                      <= '0;
            display_wr               <= 1'b0;
            display_addr             <= '0;
            display_data             <= '0;
            display_flip_framebuffer <= 1'b0;
            flip_done                <= 1'b0;
            flip_pending             <= 1'b0;
            clear_active             <= 1'b0;
            clear_addr               <= '0;
            clear_color_q            <= '0;
            vblank_q                 <= 1'b0;
        end else begin
            state                    <= state_nx;
            cnt                      <= cnt_nx;
            display_wr               <= wr_nx;
            display_addr             <= addr_nx;
            display_data             <= data_nx;
            display_flip_framebuffer <= flip_fb_nx;
            flip_done                <= done_nx;
            vblank_q                 <= vblank;

            // Clear start is only taken while idle and no flip waits, so it never races an issue.
            if (clear_issue) begin
                if (clear_addr == CLEAR_LAST) clear_active <= 1'b0;
                else                          clear_addr   <= clear_addr + 1'b1;
            end else if (clear_start && !clear_active && !flip_pending) begin
                clear_active  <= 1'b1;
                clear_addr    <= '0;
                clear_color_q <= clear_color;
            end

            if (flip_finish)   flip_pending <= 1'b0;
            else if (flip_req) flip_pending <= 1'b1;
        end
    end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sits in clk_sys between the CPU framebuffer port and the double-buffered video block's display write interface (display_addr/data/wr/busy/flip).
- Shares the single write port between two requesters: a CPU pixel-write FIFO and a hardware clear/fill engine.
- Sequences each PSRAM write against display_busy.
- Defers buffer-flip requests until all writes have drained and a vblank edge arrives, so a flip never tears or lands mid-frame.

Parameters:
- WIDTH, 267, framebuffer width in pixels.
- HEIGHT, 240, framebuffer height in pixels.
- FIFO_DEPTH, 4, CPU write FIFO entries (power of two, ≥2).
- BUSY_GUARD, 2, cycles after issuing display_wr during which display_busy is ignored.
- FLIP_PULSE, 2, cycles display_flip_framebuffer is held high.

Ports:
- clk_sys  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_ready  out  1  FIFO can accept; transfer when valid&&ready.
- cpu_wr_addr  in  20  pixel word address.
- cpu_wr_data  in  16  RGB565 pixel.
- clear_start  in  1  pulse: fill whole buffer with clear_color.
- clear_color  in  16  fill value, latched on accepted clear_start.
- clear_active  out  1  fill in progress.
- flip_req  in  1  pulse: request buffer flip.
- flip_pending  out  1  flip requested, not yet performed.
- flip_done  out  1  one-cycle pulse when the flip pulse ends.
- vblank  in  1  vblank, already synchronized to clk_sys.
- display_addr  out  20  to video block.
- display_data  out  16  to video block.
- display_wr  out  1  one-cycle write strobe.
- display_busy  in  1  write-bank busy from video block.

Behaviour:
- Reset values: all outputs 0 except cpu_wr_ready=1. FIFO emptied, clear and flip aborted, FSM in IDLE. Reset mid-write drops the write; no retry.
- FIFO:
  - Standard synchronous FIFO.
  - cpu_wr_ready = !full && !flip_pending.
  - Writes issued after a flip_req stall until flip_done, so they land in the new back buffer.
- Issue FSM states: IDLE, GUARD, WAIT, FLIP.
  - IDLE, display_busy=0:
    - FIFO non-empty: pop, drive addr/data, display_wr=1 for that single cycle, go to GUARD. CPU has fixed priority over clear.
    - Else clear_active: write clear_addr with the latched color, increment clear_addr, go to GUARD.
    - Else flip_pending, with FIFO empty, clear inactive and a vblank rising edge seen this cycle (vblank && !vblank_q): go to FLIP.
  - GUARD: count BUSY_GUARD cycles ignoring busy, then go to WAIT.
  - WAIT: stay until display_busy=0, then go to IDLE. Earliest next write is BUSY_GUARD+2 cycles after the previous one.
  - FLIP: hold display_flip_framebuffer=1 for FLIP_PULSE cycles. On exit, flip_done=1 for one cycle, clear flip_pending, go to IDLE.
- display_addr/display_data are registered and hold their last value when display_wr=0.
- Clear engine:
  - clear_start is accepted only when !clear_active && !flip_pending; otherwise ignored.
  - Accepting it sets clear_active, clear_addr=0.
  - clear_addr is 20 bits. Terminal value is WIDTH*HEIGHT-1 (64079 at defaults), computed at elaboration.
  - After that write issues, clear_active drops in the same cycle the FSM enters GUARD.
  - CPU writes interleave during a clear, taking priority. A CPU write and a clear write to the same address resolve in issue order.
- Flip:
  - flip_req sets flip_pending. A flip_req while already pending is ignored; one flip only.
  - flip_req and a cpu_wr in the same cycle: the write is accepted, since ready was still 1, and drains before the flip.
  - A vblank edge before the drain completes is missed; the flip waits for the next edge.
  - flip_req and clear_start in the same cycle: the clear is accepted first, and the flip waits for it.
- cpu_wr_addr values ≥ WIDTH*HEIGHT pass through unchanged. No bounds checking.

Decomposition:
- Package fb_sched_pkg:
  - issue-FSM state enum;
  - FB_PIXELS = WIDTH*HEIGHT helper function;
  - 20-bit address and 16-bit pixel typedefs.
- One sub-module, sync_fifo (parameterized width/depth, valid/ready), instantiated for the CPU path.

Test Plan:
- CPU writes: push (0x00010,0xF800) and (0x00011,0x07E0), busy model goes high for 5 cycles 1 cycle after each strobe -> two display_wr strobes in order with matching addr/data. The second strobe comes no earlier than busy falling.
- FIFO full: hold display_busy=1 and push 5 writes with FIFO_DEPTH=4 -> cpu_wr_ready=0 after the 4th. On busy release all 4 issue in order; the 5th is accepted afterwards.
- Clear: clear_start with color 0x001F -> exactly 64080 strobes, addresses 0..64079, all data 0x001F, then clear_active=0. Mid-clear CPU write to 0x00100 is inserted between clear strobes.
- Deferred flip: flip_req with 2 queued writes and a vblank edge arriving before they drain -> no flip on that edge. On the next edge, display_flip_framebuffer high for 2 cycles, then a flip_done pulse. cpu_wr_ready stays 0 until flip_done.
- Ignored requests: a second flip_req and a clear_start while pending -> exactly one flip, no clear.
- Reset mid-clear at clear_addr=1000 -> all outputs return to reset values next cycle. No further strobes without a new clear_start.
